pixel_repack: RTL

//  Parametrised bit-stream gearbox: packs DAT_WIDTH-bit input words into PIX_WIDTH-bit pixels,
//  LSB-first, with backpressure on both sides and frame-end flush. Successor to the fixed
//  32->24 pixel concat; sits between the DMA/stream input and the line buffers of the conv engine.

---
 rtl/pixel_repack.sv | 102 ++++++++++
 1 files changed

// File: rtl/pixel_repack.sv
// Bit-stream gearbox: packs DAT_WIDTH-bit words into PIX_WIDTH-bit pixels, LSB-first, with frame-end flush.
// Optional per-frame popped-pixel counter on opix_cnt when REPACK_STATS_EN is defined.
module pixel_repack #(
    parameter int DAT_WIDTH = 32,
    parameter int PIX_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DAT_WIDTH-1:0] idat,
    input  logic                 ival,
    input  logic                 ilast,
    output logic                 ostall,
    output logic [PIX_WIDTH-1:0] odat,
    output logic                 oval,
    output logic                 olast,
    input  logic                 ordy
`ifdef REPACK_STATS_EN
    ,
    output logic [15:0]          opix_cnt
`endif
);

    localparam int BUF_W = DAT_WIDTH + PIX_WIDTH;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] PIX_C = CNT_W'(PIX_WIDTH);
    localparam logic [CNT_W-1:0] DAT_C = CNT_W'(DAT_WIDTH);

    // Handshakes: a word moves iff ival & !ostall at a rising edge; a pixel moves iff oval & ordy.
    // Bits of data_q at index >= cnt_q are kept at zero so a push can simply OR in the new word.
    logic [BUF_W-1:0] data_q, data_s, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_s, cnt_d;
    logic             flush_q, flush_d;
    logic             push, pop;

    always_comb begin
        ostall = flush_q | (cnt_q > PIX_C);
        oval   = (cnt_q >= PIX_C) | (flush_q & (cnt_q != '0));
        olast  = oval & flush_q & (cnt_q <= PIX_C);
        odat   = '0;
        for (int i = 0; i < PIX_WIDTH; i++) begin
            odat[i] = data_q[i] & (CNT_W'(i) < cnt_q);
        end
    end

    assign pop  = oval & ordy;
    assign push = ival & ~ostall;

    always_comb begin
        data_s  = data_q;
        cnt_s   = cnt_q;
        flush_d = flush_q;
        if (pop) begin
            data_s = data_q >> PIX_WIDTH;
            cnt_s  = (cnt_q > PIX_C) ? (cnt_q - PIX_C) : '0;
            if (olast) begin
                flush_d = 1'b0;
                cnt_s   = '0;
            end
        end
        data_d = data_s;
        cnt_d  = cnt_s;
        // New word lands just above whatever survives this cycle's pop.
        if (push) begin
            data_d = data_s | (BUF_W'(idat) << cnt_s);
            cnt_d  = cnt_s + DAT_C;
            if (ilast) begin
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

`ifdef REPACK_STATS_EN
    logic [15:0] pix_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
        end else if (pop) begin
            if (olast) begin
                pix_cnt_q <= '0;
            end else if (pix_cnt_q != 16'hFFFF) begin
                pix_cnt_q <= pix_cnt_q + 16'd1;
            end
        end
    end

    assign opix_cnt = pix_cnt_q;
`endif

endmodule
